// File: rtl/fmdll_pkg.sv
// fmdll_pkg
// Shared definitions for the FMDLL frame counter: the state encoding, the
// default counter widths, and the N/M legality rule used by the controller.
package fmdll_pkg;

  // Default width of N / N_counter and of M / M_counter.
  localparam int NW_DEFAULT = 4;
  localparam int MW_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    ERR  = 2'b10
  } state_e;

  // A configuration is usable only when neither ratio is zero.
  function automatic logic cfg_legal(input int unsigned n, input int unsigned m);
    return (n != 0) && (m != 0);
  endfunction

endpackage

// File: rtl/nm_div_counter_wrap_counter.sv
// wrap_counter
// Counts 1..limit and wraps back to 1. Clear has priority over increment and
// forces the count to 1. The next count is also exported so the parent can
// register flags that line up with the registered count.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset (count returns to 1)
//   inc        - advance the count this cycle
//   clr        - force the count to 1 this cycle
//   limit      - last value before wrapping
//   count      - registered count, 1..limit
//   count_next - value the count takes at the next edge
//   wrap       - count has reached limit
module wrap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap = (count_q == limit);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = W'(1);
    end else if (inc) begin
      count_d = wrap ? W'(1) : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= W'(1);
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/nm_div_counter.sv
// nm_div_counter
// Frame counter for the FMDLL running on the multiplied clock. Divides clk_out
// by N and groups M N-periods into a frame. N and M are captured into shadow
// registers only when starting from IDLE or at a frame wrap, so a live change
// of N/M never disturbs a frame in progress. Zero ratios park the block in ERR.
//
// Ports:
//   clk_out     - multiplied DLL clock, rising edge
//   rst         - asynchronous active-high reset
//   en          - run request, honoured in IDLE and at frame wraps
//   N, M        - requested division ratio / frame length (legal when nonzero)
//   N_counter   - position in the current N-period, 1..N_act
//   M_counter   - position in the current frame, 1..M_act
//   DIV_N       - last cycle of each N-period
//   DIV_M       - first N-period of each frame
//   frame_start - first cycle of each frame
//   cfg_err     - block is in ERR
module nm_div_counter
  import fmdll_pkg::*;
#(
  parameter int NW = NW_DEFAULT,
  parameter int MW = MW_DEFAULT
) (
  input  logic          clk_out,
  input  logic          rst,
  input  logic          en,
  input  logic [NW-1:0] N,
  input  logic [MW-1:0] M,
  output logic [NW-1:0] N_counter,
  output logic [MW-1:0] M_counter,
  output logic          DIV_N,
  output logic          DIV_M,
  output logic          frame_start,
  output logic          cfg_err
);

  state_e        state_q, state_d;
  logic [NW-1:0] n_act_q, n_act_d;
  logic [MW-1:0] m_act_q, m_act_d;
  logic          div_n_q, div_n_d;
  logic          div_m_q, div_m_d;
  logic          frame_start_q, frame_start_d;
  logic          cfg_err_q, cfg_err_d;

  logic          cfg_ok;
  logic          running;
  logic          run_next;
  logic          frame_wrap;
  logic          cnt_clr;
  logic          n_wrap;
  logic          m_wrap;
  logic [NW-1:0] n_cnt_d;
  logic [MW-1:0] m_cnt_d;

  assign cfg_ok     = cfg_legal(32'(N), 32'(M));
  assign running    = (state_q == RUN);
  assign frame_wrap = running && n_wrap && m_wrap;

  always_comb begin
    state_d = state_q;
    n_act_d = n_act_q;
    m_act_d = m_act_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          if (cfg_ok) begin
            state_d = RUN;
            n_act_d = N;
            m_act_d = M;
          end else begin
            state_d = ERR;
          end
        end
      end
      RUN: begin
        if (frame_wrap) begin
          if (!en) begin
            state_d = IDLE;
          end else if (!cfg_ok) begin
            state_d = ERR;
          end else begin
            n_act_d = N;
            m_act_d = M;
          end
        end
      end
      ERR: begin
        if (cfg_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters sit at 1 outside RUN and on the edge that leaves RUN. At a frame
  // wrap that stays in RUN both counters wrap to 1 on their own, so the new
  // shadows apply from the very next cycle.
  assign run_next = (state_d == RUN);
  assign cnt_clr  = !running || !run_next;

  wrap_counter #(.W(NW)) u_n_cnt (
    .clk        (clk_out),
    .rst        (rst),
    .inc        (running),
    .clr        (cnt_clr),
    .limit      (n_act_q),
    .count      (N_counter),
    .count_next (n_cnt_d),
    .wrap       (n_wrap)
  );

  wrap_counter #(.W(MW)) u_m_cnt (
    .clk        (clk_out),
    .rst        (rst),
    .inc        (running && n_wrap),
    .clr        (cnt_clr),
    .limit      (m_act_q),
    .count      (M_counter),
    .count_next (m_cnt_d),
    .wrap       (m_wrap)
  );

  // Flags are decoded from next-cycle values so they register alongside the counts.
  always_comb begin
    div_n_d       = run_next && (n_cnt_d == n_act_d);
    div_m_d       = run_next && (m_cnt_d == MW'(1));
    frame_start_d = run_next && (n_cnt_d == NW'(1)) && (m_cnt_d == MW'(1));
    cfg_err_d     = (state_d == ERR);
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      n_act_q       <= NW'(1);
      m_act_q       <= MW'(1);
      div_n_q       <= 1'b0;
      div_m_q       <= 1'b0;
      frame_start_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_act_q       <= n_act_d;
      m_act_q       <= m_act_d;
      div_n_q       <= div_n_d;
      div_m_q       <= div_m_d;
      frame_start_q <= frame_start_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign DIV_N       = div_n_q;
  assign DIV_M       = div_m_q;
  assign frame_start = frame_start_q;
  assign cfg_err     = cfg_err_q;

endmodule
